// File: rtl/conv_window_ctrl_pkg.sv
//==============================================================================
// Module      : cnn_pkg
// Description : Shared defaults, FSM state encoding and output-map sizing for
//               the conv/pool window sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cnn_pkg;

    localparam int c_DEF_M     = 28;
    localparam int c_DEF_K     = 3;
    localparam int c_DEF_P     = 2;
    localparam int c_COORD_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Side of the output map produced by one layer.
    function automatic int out_dim(input int pool, input int m, input int k, input int p);
        return (pool != 0) ? (m / p) : (m - k + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_window_ctrl_if.sv
//==============================================================================
// Module      : conv_window_ctrl_if
// Description : Pixel-stream / window handshake bundle of conv_window_ctrl.
//               CONV_WIN_CTRL_ERR_EN adds the err_sticky status line.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface conv_window_ctrl_if;
    import cnn_pkg::*;

    logic                 start;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 out_ready;
    logic                 shift_en;
    logic                 win_valid;
    logic [c_COORD_W-1:0] win_row;
    logic [c_COORD_W-1:0] win_col;
    logic                 frame_done;
    logic                 busy;
`ifdef CONV_WIN_CTRL_ERR_EN
    logic                 err_sticky;
`endif

    modport master (
        output start, pix_valid, out_ready,
        input  pix_ready, shift_en, win_valid, win_row, win_col, frame_done, busy
`ifdef CONV_WIN_CTRL_ERR_EN
        , input err_sticky
`endif
    );

    modport slave (
        input  start, pix_valid, out_ready,
        output pix_ready, shift_en, win_valid, win_row, win_col, frame_done, busy
`ifdef CONV_WIN_CTRL_ERR_EN
        , output err_sticky
`endif
    );

endinterface

`default_nettype wire

// File: rtl/conv_window_ctrl_wrap_cnt.sv
//==============================================================================
// Module      : wrap_cnt
// Description : Modulo-N up counter with enable, synchronous clear and a
//               wrap pulse that fires on the enabled N-1 -> 0 step.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wrap_cnt #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  wire          clk,
    input  wire          reset,
    input  wire          i_clear,
    input  wire          i_en,
    output logic [W-1:0] o_count,
    output logic         o_wrap
);

    logic [W-1:0] r_count;
    logic         w_at_max;

    assign w_at_max = (r_count == W'(N - 1));
    assign o_wrap   = i_en & w_at_max;
    assign o_count  = r_count;

    // Clear has priority so a frame restart or line wrap wins over a step.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_at_max ? '0 : r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_window_ctrl.sv
//==============================================================================
// Module      : conv_window_ctrl
// Description : Raster-stream sequencer for a conv (KxK, stride 1) or pool
//               (PxP, stride P) line-buffer datapath; flags complete windows.
//               CONV_WIN_CTRL_ERR_EN adds a sticky protocol-error flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module conv_window_ctrl
    import cnn_pkg::*;
#(
    parameter int POOL = 0,
    parameter int M    = c_DEF_M,
    parameter int K    = c_DEF_K,
    parameter int P    = c_DEF_P
) (
    input  wire               clk,
    input  wire               reset,
    conv_window_ctrl_if.slave bus
);

    localparam int c_OUT = out_dim(POOL, M, K, P);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_run;
    logic                 w_busy;
    logic                 w_frame_done;
    logic                 w_frame_start;
    logic                 w_pending;
    logic                 w_pix_ready;
    logic                 w_shift;
    logic                 w_win_fire;
    logic                 w_col_wrap;
    logic                 w_last_pix;
    logic                 w_wcol_wrap;
    logic                 w_unused_wrow_wrap;
    logic [c_COORD_W-1:0] w_row;
    logic [c_COORD_W-1:0] w_col;
    logic [c_COORD_W-1:0] w_wrow;
    logic [c_COORD_W-1:0] w_wcol;
    logic                 r_win_valid;
    logic [c_COORD_W-1:0] r_win_row;
    logic [c_COORD_W-1:0] r_win_col;

    //--------------------------------------------------------------------------
    // Frame FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_busy        = 1'b1;
        w_frame_done  = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_frame_start = 1'b1;
                    w_state_nxt   = RUN;
                end
            end
            RUN: begin
                if (w_last_pix) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_frame_done = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Only a pixel that would complete a window needs downstream room.
    assign w_run       = (r_state == RUN);
    assign w_pix_ready = w_run & (bus.out_ready | ~w_pending);
    assign w_shift     = bus.pix_valid & w_pix_ready;
    assign w_win_fire  = w_shift & w_pending;

    //--------------------------------------------------------------------------
    // Input raster position
    //--------------------------------------------------------------------------
    wrap_cnt #(.N(M), .W(c_COORD_W)) u_col_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_frame_start),
        .i_en    (w_shift),
        .o_count (w_col),
        .o_wrap  (w_col_wrap)
    );

    wrap_cnt #(.N(M), .W(c_COORD_W)) u_row_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_frame_start),
        .i_en    (w_col_wrap),
        .o_count (w_row),
        .o_wrap  (w_last_pix)
    );

    //--------------------------------------------------------------------------
    // Window-completion detect
    //--------------------------------------------------------------------------
    generate
        if (POOL != 0) begin : g_pool
            logic [c_COORD_W-1:0] w_scol;
            logic [c_COORD_W-1:0] w_srow;
            logic                 w_unused_scol_wrap;
            logic                 w_unused_srow_wrap;

            // Phase counters restart on every line/frame wrap so a partial
            // trailing tile never reaches phase P-1 in both dimensions.
            wrap_cnt #(.N(P), .W(c_COORD_W)) u_scol_cnt (
                .clk     (clk),
                .reset   (reset),
                .i_clear (w_frame_start | w_col_wrap),
                .i_en    (w_shift),
                .o_count (w_scol),
                .o_wrap  (w_unused_scol_wrap)
            );

            wrap_cnt #(.N(P), .W(c_COORD_W)) u_srow_cnt (
                .clk     (clk),
                .reset   (reset),
                .i_clear (w_frame_start | w_last_pix),
                .i_en    (w_col_wrap),
                .o_count (w_srow),
                .o_wrap  (w_unused_srow_wrap)
            );

            assign w_pending = (w_scol == c_COORD_W'(P - 1)) &&
                               (w_srow == c_COORD_W'(P - 1));
        end else begin : g_conv
            assign w_pending = (w_row >= c_COORD_W'(K - 1)) &&
                               (w_col >= c_COORD_W'(K - 1));
        end
    endgenerate

    //--------------------------------------------------------------------------
    // Output-map coordinates of the next window to be flagged
    //--------------------------------------------------------------------------
    wrap_cnt #(.N(c_OUT), .W(c_COORD_W)) u_wcol_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_frame_start),
        .i_en    (w_win_fire),
        .o_count (w_wcol),
        .o_wrap  (w_wcol_wrap)
    );

    wrap_cnt #(.N(c_OUT), .W(c_COORD_W)) u_wrow_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_frame_start),
        .i_en    (w_wcol_wrap),
        .o_count (w_wrow),
        .o_wrap  (w_unused_wrow_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else begin
            r_win_valid <= w_win_fire;
            if (w_win_fire) begin
                r_win_row <= w_wrow;
                r_win_col <= w_wcol;
            end
        end
    end

`ifdef CONV_WIN_CTRL_ERR_EN
    logic r_err_sticky;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_sticky <= 1'b0;
        end else if ((bus.start & w_busy) | (bus.pix_valid & ~w_busy)) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign bus.err_sticky = r_err_sticky;
`endif

    assign bus.pix_ready  = w_pix_ready;
    assign bus.shift_en   = w_shift;
    assign bus.win_valid  = r_win_valid;
    assign bus.win_row    = r_win_row;
    assign bus.win_col    = r_win_col;
    assign bus.frame_done = w_frame_done;
    assign bus.busy       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
//==============================================================================
// Module      : tb_conv_window_ctrl
// Description : Drives a conv (POOL=0) and a pool (POOL=1) instance from one
//               shared stream and scoreboards every window against a model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_conv_window_ctrl;

    localparam int M       = 28;
    localparam int K       = 3;
    localparam int P       = 2;
    localparam int NI      = 2;
    localparam int BUDGET  = 20000;
    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_DONE = 2;
    localparam int POOL_OF  [NI] = '{0, 1};
    localparam int FIRST_OF [NI] = '{59, 30};
    localparam int LAST_OF  [NI] = '{25, 13};

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
    } exp_t;

    typedef struct {
        int vpct;
        int rpct;
        int start_at;
        int bp_at;
        int rst_at;
        int exp_win0;
        int exp_win1;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic pix_valid = 1'b0;
    logic out_ready = 1'b0;

    always #5 clk = ~clk;

    conv_window_ctrl_if bus0 ();
    conv_window_ctrl_if bus1 ();

    assign bus0.start     = start;
    assign bus0.pix_valid = pix_valid;
    assign bus0.out_ready = out_ready;
    assign bus1.start     = start;
    assign bus1.pix_valid = pix_valid;
    assign bus1.out_ready = out_ready;

    conv_window_ctrl #(.POOL(0), .M(M), .K(K), .P(P)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    conv_window_ctrl #(.POOL(1), .M(M), .K(K), .P(P)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int   n_checks = 0;
    int   n_err    = 0;
    int   m_st     [NI];
    int   m_r      [NI];
    int   m_c      [NI];
    int   m_pushed [NI];
    int   m_seen   [NI];
    int   m_npix   [NI];
    int   m_first  [NI];
    int   m_last_r [NI];
    int   m_last_c [NI];
    bit   m_err    [NI];
    exp_t q        [NI][$];
    logic s_pr [NI], s_se [NI], s_wv [NI], s_fd [NI], s_busy [NI], s_err [NI];
    logic [7:0] s_wr [NI], s_wc [NI];

    task automatic check(input string name, input int id, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, id, act, exp, $time);
        end
    endtask

    function automatic bit pend(input int id);
        if (m_st[id] != ST_RUN) return 1'b0;
        if (POOL_OF[id] != 0) return ((m_r[id] % P) == P - 1) && ((m_c[id] % P) == P - 1);
        return (m_r[id] >= K - 1) && (m_c[id] >= K - 1);
    endfunction

    task automatic monitor();
        s_pr[0] = bus0.pix_ready;  s_pr[1] = bus1.pix_ready;
        s_se[0] = bus0.shift_en;   s_se[1] = bus1.shift_en;
        s_wv[0] = bus0.win_valid;  s_wv[1] = bus1.win_valid;
        s_wr[0] = bus0.win_row;    s_wr[1] = bus1.win_row;
        s_wc[0] = bus0.win_col;    s_wc[1] = bus1.win_col;
        s_fd[0] = bus0.frame_done; s_fd[1] = bus1.frame_done;
        s_busy[0] = bus0.busy;     s_busy[1] = bus1.busy;
`ifdef CONV_WIN_CTRL_ERR_EN
        s_err[0] = bus0.err_sticky; s_err[1] = bus1.err_sticky;
`else
        s_err[0] = 1'b0; s_err[1] = 1'b0;
`endif
        for (int id = 0; id < NI; id++) begin
            bit   p;
            bit   epr;
            bit   esh;
            exp_t e;
            p   = pend(id);
            epr = (m_st[id] == ST_RUN) && (out_ready || !p);
            esh = pix_valid && epr;
            check("pix_ready", id, s_pr[id], epr);
            check("shift_en", id, s_se[id], esh);
            check("busy", id, s_busy[id], m_st[id] != ST_IDLE);
            check("frame_done", id, s_fd[id], m_st[id] == ST_DONE);
`ifdef CONV_WIN_CTRL_ERR_EN
            check("err_sticky", id, s_err[id], m_err[id]);
`endif
            check("win_valid", id, s_wv[id], q[id].size() != 0);
            if (s_wv[id] && q[id].size() != 0) begin
                e = q[id].pop_front();
                check("win_row", id, s_wr[id], e.row);
                check("win_col", id, s_wc[id], e.col);
                if (m_seen[id] == 0) m_first[id] = m_npix[id];
                m_seen[id]++;
                m_last_r[id] = s_wr[id];
                m_last_c[id] = s_wc[id];
            end
            // Advance the model to the state the coming clock edge produces.
            if (reset) begin
                m_st[id] = ST_IDLE;
                m_r[id]  = 0;
                m_c[id]  = 0;
                m_err[id] = 1'b0;
                q[id].delete();
            end else begin
                if ((start && m_st[id] != ST_IDLE) || (pix_valid && m_st[id] == ST_IDLE))
                    m_err[id] = 1'b1;
                case (m_st[id])
                    ST_IDLE: if (start) m_st[id] = ST_RUN;
                    ST_RUN: if (esh) begin
                        if (p) begin
                            e.row = (POOL_OF[id] != 0) ? 8'(m_r[id] / P) : 8'(m_r[id] - (K - 1));
                            e.col = (POOL_OF[id] != 0) ? 8'(m_c[id] / P) : 8'(m_c[id] - (K - 1));
                            q[id].push_back(e);
                            m_pushed[id]++;
                        end
                        m_npix[id]++;
                        if (m_r[id] == M - 1 && m_c[id] == M - 1) m_st[id] = ST_DONE;
                        if (m_c[id] == M - 1) begin
                            m_c[id] = 0;
                            m_r[id] = (m_r[id] == M - 1) ? 0 : m_r[id] + 1;
                        end else begin
                            m_c[id]++;
                        end
                    end
                    default: m_st[id] = ST_IDLE;
                endcase
            end
        end
    endtask

    always @(negedge clk) monitor();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_pix_ready"}, 0, bus0.pix_ready, 0);
        check({tag, "_shift_en"}, 0, bus0.shift_en, 0);
        check({tag, "_win_valid"}, 0, bus0.win_valid, 0);
        check({tag, "_win_row"}, 0, bus0.win_row, 0);
        check({tag, "_win_col"}, 0, bus0.win_col, 0);
        check({tag, "_frame_done"}, 0, bus0.frame_done, 0);
        check({tag, "_busy"}, 0, bus0.busy, 0);
        check({tag, "_win_valid"}, 1, bus1.win_valid, 0);
        check({tag, "_win_row"}, 1, bus1.win_row, 0);
        check({tag, "_win_col"}, 1, bus1.win_col, 0);
        check({tag, "_busy"}, 1, bus1.busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v, output bit aborted);
        int cyc;
        int bp_left;
        bit bp_done;
        bit st_done;
        bit rst_done;
        aborted = 1'b0; cyc = 0; bp_left = 0;
        bp_done = 1'b0; st_done = 1'b0; rst_done = 1'b0;
        for (int id = 0; id < NI; id++) begin
            m_seen[id] = 0; m_pushed[id] = 0; m_npix[id] = 0; m_first[id] = -1;
        end
        start = 1'b1; pix_valid = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b0;
        while ((m_st[0] != ST_IDLE || m_st[1] != ST_IDLE) && cyc < BUDGET && !aborted) begin
            pix_valid = ($urandom_range(99) < v.vpct);
            out_ready = ($urandom_range(99) < v.rpct);
            start     = 1'b0;
            if (v.bp_at >= 0 && !bp_done && m_pushed[0] == v.bp_at && pend(0)) begin
                bp_left = 5;
                bp_done = 1'b1;
            end
            if (bp_left > 0) begin
                pix_valid = 1'b1;
                out_ready = 1'b0;
            end
            if (v.start_at >= 0 && !st_done && m_npix[0] == v.start_at) begin
                start   = 1'b1;
                st_done = 1'b1;
            end
            if (v.rst_at >= 0 && !rst_done && m_npix[0] == v.rst_at) begin
                reset    = 1'b1;
                rst_done = 1'b1;
            end
            @(negedge clk);
            if (bp_left > 0) begin
                check("stall_pix_ready", 0, bus0.pix_ready, 0);
                check("stall_shift_en", 0, bus0.shift_en, 0);
                bp_left--;
            end
            @(posedge clk);
            #1;
            if (reset) begin
                reset = 1'b0; start = 1'b0; pix_valid = 1'b0;
                check_reset_outputs("after_reset");
                aborted = 1'b1;
            end
            cyc++;
        end
        start = 1'b0; pix_valid = 1'b0; out_ready = 1'b1;
        if (cyc >= BUDGET) check("frame_timeout", 0, 1, 0);
    endtask

    vec_t tbl [7];

    initial begin
        bit aborted;
        tbl[0] = '{100, 100,  -1, -1,  -1, 676, 196};
        tbl[1] = '{100, 100,  -1, 10,  -1, 676, 196};
        tbl[2] = '{100, 100,  -1, -1, 300,   0,   0};
        tbl[3] = '{100, 100, 400, -1,  -1, 676, 196};
        tbl[4] = '{ 70,  80,  -1, -1,  -1, 676, 196};
        tbl[5] = '{ 90,  50,  -1, -1,  -1, 676, 196};
        tbl[6] = '{ 60,  60,  -1, -1,  -1, 676, 196};

        repeat (3) tick();
        reset = 1'b0;
        check_reset_outputs("reset_state");

        // A source that raises pix_valid before start must not be accepted.
        pix_valid = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_pix_ready", 0, bus0.pix_ready, 0);
            check("idle_shift_en", 1, bus1.shift_en, 0);
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i], aborted);
            if (!aborted) begin
                check("windows", 0, m_seen[0], tbl[i].exp_win0);
                check("windows", 1, m_seen[1], tbl[i].exp_win1);
                for (int id = 0; id < NI; id++) begin
                    check("first_window_pixels", id, m_first[id], FIRST_OF[id]);
                    check("last_win_row", id, m_last_r[id], LAST_OF[id]);
                    check("last_win_col", id, m_last_c[id], LAST_OF[id]);
                    check("leftover_windows", id, q[id].size(), 0);
                end
            end
            repeat (2) tick();
        end

`ifdef CONV_WIN_CTRL_ERR_EN
        @(negedge clk);
        check("err_held", 0, bus0.err_sticky, 1);
        check("err_held", 1, bus1.err_sticky, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("err_cleared", 0, bus0.err_sticky, 0);
        check("err_cleared", 1, bus1.err_sticky, 0);
        @(posedge clk);
        #1;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
